// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the host.
// Words land either directly in the output register (when it is free and the
// RAM is empty) or in a circular RAM behind it. The output register is also the
// registered read port of that RAM, so a word written into an empty FIFO is
// visible one edge later, and a consumer holding ready high drains one word
// per cycle.
module uart_rx_fifo #(
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH      = 16,
    parameter int P_AFULL_THRESH    = 12
) (
    input  logic                               i_u_clk,
    input  logic                               i_u_rst_n,
    input  logic [P_UART_DATA_WIDTH-1:0]       i_rx_data,
    input  logic                               i_rx_valid,
    output logic [P_UART_DATA_WIDTH-1:0]       o_rd_data,
    output logic                               o_rd_valid,
    input  logic                               i_rd_ready,
    output logic [$clog2(P_FIFO_DEPTH):0]      o_fifo_level,
    output logic                               o_almost_full,
    output logic                               o_overflow,
    input  logic                               i_clr_overflow
);

    localparam int PW = $clog2(P_FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(P_FIFO_DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(P_AFULL_THRESH);

    // The RAM is sized to the full power-of-two depth so pointers wrap
    // naturally; at most P_FIFO_DEPTH-1 entries are ever occupied because the
    // output register holds the remaining word.
    logic [P_UART_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];

    logic [PW-1:0]                wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]                rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]                ram_count_reg, ram_count_next;
    logic [LW-1:0]                level_reg, level_next;
    logic [P_UART_DATA_WIDTH-1:0] rd_data_reg;
    logic                         rd_valid_reg, rd_valid_next;
    logic                         almost_full_reg, almost_full_next;
    logic                         overflow_reg, overflow_next;

    logic rd_xfer;
    logic wr_accept;
    logic drop;
    logic out_free;
    logic ram_empty;
    logic load_from_ram;
    logic load_from_input;
    logic ram_write;

    // Handshake decode, datapath steering and next-state arithmetic.
    always_comb begin
        rd_xfer          = 1'b0;
        wr_accept        = 1'b0;
        drop             = 1'b0;
        out_free         = 1'b0;
        ram_empty        = 1'b0;
        load_from_ram    = 1'b0;
        load_from_input  = 1'b0;
        ram_write        = 1'b0;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        ram_count_next   = ram_count_reg;
        level_next       = level_reg;
        rd_valid_next    = rd_valid_reg;
        almost_full_next = almost_full_reg;
        overflow_next    = overflow_reg;

        rd_xfer   = rd_valid_reg && i_rd_ready;
        // A read in the same cycle frees a slot, so a full FIFO still accepts.
        wr_accept = i_rx_valid && ((level_reg < DEPTH_L) || rd_xfer);
        drop      = i_rx_valid && !wr_accept;

        // Output register can take a new word if it is empty or being consumed.
        out_free  = !rd_valid_reg || rd_xfer;
        ram_empty = (ram_count_reg == '0);

        // RAM contents are older than the incoming word, so they go first;
        // the incoming word bypasses the RAM only when nothing is queued.
        load_from_ram   = out_free && !ram_empty;
        load_from_input = out_free && ram_empty && wr_accept;
        ram_write       = wr_accept && !load_from_input;

        wr_ptr_next    = wr_ptr_reg + PW'(ram_write);
        rd_ptr_next    = rd_ptr_reg + PW'(load_from_ram);
        ram_count_next = ram_count_reg + LW'(ram_write) - LW'(load_from_ram);

        rd_valid_next  = out_free ? (load_from_ram || load_from_input) : 1'b1;

        level_next       = level_reg + LW'(wr_accept) - LW'(rd_xfer);
        almost_full_next = (level_next >= AFULL_L);

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (i_clr_overflow) begin
            overflow_next = 1'b0;
        end
    end

    // Control and status registers, plus the output register that doubles as
    // the RAM's registered read port.
    always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
        if (!i_u_rst_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            ram_count_reg   <= '0;
            level_reg       <= '0;
            rd_data_reg     <= '0;
            rd_valid_reg    <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            ram_count_reg   <= ram_count_next;
            level_reg       <= level_next;
            rd_valid_reg    <= rd_valid_next;
            almost_full_reg <= almost_full_next;
            overflow_reg    <= overflow_next;
            // Data holds its last value when nothing new is loaded.
            if (load_from_ram) begin
                rd_data_reg <= mem[rd_ptr_reg];
            end else if (load_from_input) begin
                rd_data_reg <= i_rx_data;
            end
        end
    end

    // RAM write port; no reset so it maps onto block RAM. Stale contents are
    // unreachable after reset because the pointers and count restart at zero.
    always_ff @(posedge i_u_clk) begin
        if (ram_write) begin
            mem[wr_ptr_reg] <= i_rx_data;
        end
    end

    assign o_rd_data     = rd_data_reg;
    assign o_rd_valid    = rd_valid_reg;
    assign o_fifo_level  = level_reg;
    assign o_almost_full = almost_full_reg;
    assign o_overflow    = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a scoreboard queue receives every word the bench
// expects to be accepted; a monitor pops and compares on each read transfer.
module tb_uart_rx_fifo;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int LW = $clog2(D) + 1;

    logic          i_u_clk = 1'b0;
    logic          i_u_rst_n = 1'b0;
    logic [W-1:0]  i_rx_data = '0;
    logic          i_rx_valid = 1'b0;
    logic [W-1:0]  o_rd_data;
    logic          o_rd_valid;
    logic          i_rd_ready = 1'b0;
    logic [LW-1:0] o_fifo_level;
    logic          o_almost_full;
    logic          o_overflow;
    logic          i_clr_overflow = 1'b0;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] mon_exp;
    int           m_level = 0;

    uart_rx_fifo #(
        .P_UART_DATA_WIDTH (W),
        .P_FIFO_DEPTH      (D),
        .P_AFULL_THRESH    (AF)
    ) dut (
        .i_u_clk        (i_u_clk),
        .i_u_rst_n      (i_u_rst_n),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_fifo_level   (o_fifo_level),
        .o_almost_full  (o_almost_full),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    always #5 i_u_clk = ~i_u_clk;

    // Inputs change just after rising edges, so at the falling edge the
    // handshake for the coming edge is settled.
    always @(negedge i_u_clk) begin
        if (i_u_rst_n && o_rd_valid && i_rd_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h, scoreboard empty", o_rd_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (o_rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h, expected %h", o_rd_data, mon_exp);
                end else begin
                    $display("read %h", o_rd_data);
                end
            end
        end
    end

    // One clock of stimulus; pushes the word to the scoreboard if the FIFO
    // should accept it.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic rdy, input logic clr);
        logic rd, wr;
        i_rx_valid = v;
        i_rx_data = d;
        i_rd_ready = rdy;
        i_clr_overflow = clr;
        rd = (m_level > 0) && rdy;
        wr = v && ((m_level < D) || rd);
        if (wr) sb_q.push_back(d);
        m_level = m_level + int'(wr) - int'(rd);
        @(posedge i_u_clk);
        #1;
        i_rx_valid = 1'b0;
        i_rd_ready = 1'b0;
        i_clr_overflow = 1'b0;
    endtask

    task automatic test_reset();
        i_u_rst_n = 1'b0;
        repeat (3) @(posedge i_u_clk);
        #1;
        vectors += 5;
        if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", o_rd_valid); end
        if (o_rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", o_rd_data); end
        if (o_fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", o_fifo_level); end
        if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b, expected 0", o_almost_full); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", o_overflow); end
        i_u_rst_n = 1'b1;
        @(posedge i_u_clk);
        #1;
    endtask

    task automatic test_single();
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        vectors += 3;
        if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", o_rd_valid); end
        if (o_rd_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, expected a5", o_rd_data); end
        if (o_fifo_level !== LW'(1)) begin errors++; $display("FAIL single_level: got %0d, expected 1", o_fifo_level); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            vectors++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA5) begin
                errors++;
                $display("FAIL single_hold: got valid=%b data=%h, expected valid=1 data=a5", o_rd_valid, o_rd_data);
            end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors += 2;
        if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b, expected 0", o_rd_valid); end
        if (o_fifo_level !== LW'(0)) begin errors++; $display("FAIL single_drain_level: got %0d, expected 0", o_fifo_level); end
        vectors++;
        if (o_rd_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h, expected a5", o_rd_data); end
    endtask

    task automatic test_fill_overflow_drain();
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, W'(i), 1'b0, 1'b0);
            vectors += 2;
            if (o_fifo_level !== LW'(i + 1)) begin errors++; $display("FAIL fill_level: got %0d, expected %0d", o_fifo_level, i + 1); end
            if (o_almost_full !== ((i + 1) >= AF)) begin errors++; $display("FAIL fill_afull: got %b at level %0d", o_almost_full, i + 1); end
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        vectors += 2;
        if (o_fifo_level !== LW'(D)) begin errors++; $display("FAIL drop_level: got %0d, expected %0d", o_fifo_level, D); end
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf: got %b, expected 1", o_overflow); end
        for (int i = 0; i < D; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            vectors += 2;
            if (o_fifo_level !== LW'(D - 1 - i)) begin errors++; $display("FAIL drain_level: got %0d, expected %0d", o_fifo_level, D - 1 - i); end
            if (o_almost_full !== ((D - 1 - i) >= AF)) begin errors++; $display("FAIL drain_afull: got %b at level %0d", o_almost_full, D - 1 - i); end
        end
        vectors += 3;
        if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid %b, expected 0", o_rd_valid); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL drain_leftover: got %0d words left, expected 0", sb_q.size()); end
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", o_overflow); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", o_overflow); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < D; i++) cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        vectors += 2;
        if (o_fifo_level !== LW'(D)) begin errors++; $display("FAIL simul_level: got %0d, expected %0d", o_fifo_level, D); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b, expected 0", o_overflow); end
        vectors++;
        if (sb_q.size() == 0 || sb_q[sb_q.size() - 1] !== 8'h55) begin
            errors++;
            $display("FAIL simul_queue: scoreboard tail not 55");
        end
        for (int i = 0; i < D; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors += 2;
        if (o_rd_data !== 8'h55) begin errors++; $display("FAIL simul_last: got %h, expected 55", o_rd_data); end
        if (sb_q.size() != 0 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %0d left valid=%b, expected 0 left valid=0", sb_q.size(), o_rd_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, W'($urandom_range(0, 255)), 1'b1, 1'b0);
            vectors++;
            if (o_fifo_level > LW'(1) || o_overflow !== 1'b0) begin
                errors++;
                $display("FAIL stream_level: got level %0d ovf %b, expected level<=1 ovf 0", o_fifo_level, o_overflow);
            end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (sb_q.size() != 0 || o_fifo_level !== LW'(0)) begin
            errors++;
            $display("FAIL stream_end: got %0d left level %0d, expected 0 and 0", sb_q.size(), o_fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) cycle(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (o_fifo_level !== LW'(7)) begin errors++; $display("FAIL mid_level: got %0d, expected 7", o_fifo_level); end
        i_u_rst_n = 1'b0;
        #1;
        vectors += 4;
        if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", o_rd_valid); end
        if (o_rd_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h, expected 00", o_rd_data); end
        if (o_fifo_level !== LW'(0)) begin errors++; $display("FAIL mid_rst_level: got %0d, expected 0", o_fifo_level); end
        if (o_almost_full !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got af=%b ovf=%b, expected 0 0", o_almost_full, o_overflow); end
        sb_q.delete();
        m_level = 0;
        repeat (2) @(posedge i_u_clk);
        #1;
        i_u_rst_n = 1'b1;
        @(posedge i_u_clk);
        #1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        vectors++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h3C) begin errors++; $display("FAIL mid_post: got valid=%b data=%h, expected 1 3c", o_rd_valid, o_rd_data); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_extra: got valid %b, expected 0", o_rd_valid); end
        end
    endtask

    task automatic test_clr_with_drop();
        for (int i = 0; i < D; i++) cycle(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        vectors++;
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL clr_drop: got %b, expected 1", o_overflow); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL clr_after: got %b, expected 0", o_overflow); end
        for (int i = 0; i < D; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (sb_q.size() != 0 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL clr_drain: got %0d left valid=%b, expected 0 0", sb_q.size(), o_rd_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow_drain();
        test_full_simul();
        test_back_to_back();
        test_reset_mid();
        test_clr_with_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
